mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 178 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arbiter
//  Purpose  : Two-port memory arbiter. A core port (c_*) and a programming
//             loader port (p_*) share one downstream memory port (m_*).
//             Round-robin between the two in normal operation; in
//             programming mode only the loader may issue. Up to OUTST
//             transactions may be outstanding; responses return in order
//             and are steered to the recorded owner through a small FIFO.
//  Ports    : clk, rst (async, active-low)
//             prog_mode_i                 - lock the core port out
//             c_req/gnt/addr/we/be/wdata  - core request channel
//             c_rvalid/err/rdata          - core response channel
//             p_req/gnt/addr/we/wdata     - loader request (byte enables = all ones)
//             p_rvalid/err/rdata          - loader response channel
//             m_req/gnt/addr/we/be/wdata  - downstream request channel
//             m_rvalid/err/rdata          - downstream response channel
//             outst_o                     - outstanding transaction count
//             spurious_o                  - sticky: response with nothing outstanding
//  Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
   parameter int MEM_W = 32,
   parameter int OUTST = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         prog_mode_i,
   // core port
   input  logic                         c_req_i,
   output logic                         c_gnt_o,
   input  logic [31:0]                  c_addr_i,
   input  logic                         c_we_i,
   input  logic [MEM_W/8-1:0]           c_be_i,
   input  logic [MEM_W-1:0]             c_wdata_i,
   output logic                         c_rvalid_o,
   output logic                         c_err_o,
   output logic [MEM_W-1:0]             c_rdata_o,
   // programming-loader port
   input  logic                         p_req_i,
   input  logic [31:0]                  p_addr_i,
   input  logic                         p_we_i,
   input  logic [MEM_W-1:0]             p_wdata_i,
   output logic                         p_gnt_o,
   output logic                         p_rvalid_o,
   output logic                         p_err_o,
   output logic [MEM_W-1:0]             p_rdata_o,
   // downstream port
   output logic                         m_req_o,
   output logic [31:0]                  m_addr_o,
   output logic                         m_we_o,
   output logic [MEM_W/8-1:0]           m_be_o,
   output logic [MEM_W-1:0]             m_wdata_o,
   input  logic                         m_gnt_i,
   input  logic                         m_rvalid_i,
   input  logic                         m_err_i,
   input  logic [MEM_W-1:0]             m_rdata_i,
   // status
   output logic [$clog2(OUTST+1)-1:0]   outst_o,
   output logic                         spurious_o
);

   localparam int CNT_W = $clog2(OUTST + 1);
   localparam int PTR_W = $clog2(OUTST);
   localparam int BE_W  = MEM_W / 8;
   localparam logic [CNT_W-1:0] c_FULL_CNT = CNT_W'(OUTST);

   // ---------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------
   logic                r_last;          // 1 = loader was granted last
   logic [CNT_W-1:0]    r_cnt;
   logic [PTR_W-1:0]    r_wptr;
   logic [PTR_W-1:0]    r_rptr;
   logic [OUTST-1:0]    r_owner;         // owner id per slot: 0 = core, 1 = loader
   logic                r_spur;
   logic                r_c_rvalid;
   logic                r_c_err;
   logic [MEM_W-1:0]    r_c_rdata;
   logic                r_p_rvalid;
   logic                r_p_err;
   logic [MEM_W-1:0]    r_p_rdata;

   // ---------------------------------------------------------------------
   // Arbitration
   // ---------------------------------------------------------------------
   logic w_sel_p;
   logic w_sel_req;
   logic w_not_full;
   logic w_issue;
   logic w_hs;
   logic w_pop;
   logic w_drop;
   logic w_head;

   // In programming mode the loader is always the selected port, so the
   // core can never reach the downstream port. Otherwise the loader wins
   // when it is alone or when the core was granted last.
   assign w_sel_p    = prog_mode_i ? 1'b1 : (p_req_i & (~c_req_i | ~r_last));
   assign w_sel_req  = w_sel_p ? p_req_i : c_req_i;
   // Full blocks issue even if a response pops this cycle: the count is
   // the registered value, not the post-pop value.
   assign w_not_full = (r_cnt < c_FULL_CNT);
   // Gating with rst keeps the combinational request/grants quiet while
   // reset is held.
   assign w_issue    = rst & w_sel_req & w_not_full;
   assign w_hs       = w_issue & m_gnt_i;

   assign w_head     = r_owner[r_rptr];
   assign w_pop      = m_rvalid_i & (r_cnt != '0);
   assign w_drop     = m_rvalid_i & (r_cnt == '0);

   assign m_req_o    = w_issue;
   assign m_addr_o   = w_sel_p ? p_addr_i  : c_addr_i;
   assign m_we_o     = w_sel_p ? p_we_i    : c_we_i;
   assign m_be_o     = w_sel_p ? {BE_W{1'b1}} : c_be_i;
   assign m_wdata_o  = w_sel_p ? p_wdata_i : c_wdata_i;

   assign c_gnt_o    = w_hs & ~w_sel_p;
   assign p_gnt_o    = w_hs &  w_sel_p;

   // ---------------------------------------------------------------------
   // Owner FIFO, counters and registered responses
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_last     <= 1'b1;             // core wins the first tie
         r_cnt      <= '0;
         r_wptr     <= '0;
         r_rptr     <= '0;
         r_owner    <= '0;
         r_spur     <= 1'b0;
         r_c_rvalid <= 1'b0;
         r_c_err    <= 1'b0;
         r_c_rdata  <= '0;
         r_p_rvalid <= 1'b0;
         r_p_err    <= 1'b0;
         r_p_rdata  <= '0;
      end else begin
         if (w_hs) begin
            r_owner[r_wptr] <= w_sel_p;
            r_wptr          <= r_wptr + PTR_W'(1);   // wraps modulo OUTST
            r_last          <= w_sel_p;
         end
         if (w_pop) begin
            r_rptr <= r_rptr + PTR_W'(1);
         end
         r_cnt <= r_cnt + CNT_W'(w_hs) - CNT_W'(w_pop);

         if (w_drop) begin
            r_spur <= 1'b1;
         end

         r_c_rvalid <= w_pop & ~w_head;
         r_c_err    <= w_pop & ~w_head & m_err_i;
         if (w_pop & ~w_head) begin
            r_c_rdata <= m_rdata_i;
         end

         r_p_rvalid <= w_pop & w_head;
         r_p_err    <= w_pop & w_head & m_err_i;
         if (w_pop & w_head) begin
            r_p_rdata <= m_rdata_i;
         end
      end
   end

   assign outst_o    = r_cnt;
   assign spurious_o = r_spur;
   assign c_rvalid_o = r_c_rvalid;
   assign c_err_o    = r_c_err;
   assign c_rdata_o  = r_c_rdata;
   assign p_rvalid_o = r_p_rvalid;
   assign p_err_o    = r_p_err;
   assign p_rdata_o  = r_p_rdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_arbiter
//  Purpose  : Self-checking bench for mem_arbiter (MEM_W=32, OUTST=4).
//             A reference model of arbitration, outstanding count and the
//             owner FIFO runs alongside the DUT; expected responses are
//             queued when a downstream response is driven and compared when
//             the DUT presents rvalid.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;
   localparam int MEM_W = 32;
   localparam int OUTST = 4;

   logic        clk, rst, prog_mode_i;
   logic        c_req_i, c_we_i, p_req_i, p_we_i;
   logic [31:0] c_addr_i, p_addr_i, c_wdata_i, p_wdata_i;
   logic [3:0]  c_be_i;
   logic        m_gnt_i, m_rvalid_i, m_err_i;
   logic [31:0] m_rdata_i;
   logic        c_gnt_o, c_rvalid_o, c_err_o, p_gnt_o, p_rvalid_o, p_err_o;
   logic [31:0] c_rdata_o, p_rdata_o;
   logic        m_req_o, m_we_o;
   logic [31:0] m_addr_o, m_wdata_o;
   logic [3:0]  m_be_o;
   logic [2:0]  outst_o;
   logic        spurious_o;

   mem_arbiter #(.MEM_W(MEM_W), .OUTST(OUTST)) dut (
      .clk(clk), .rst(rst), .prog_mode_i(prog_mode_i),
      .c_req_i(c_req_i), .c_gnt_o(c_gnt_o), .c_addr_i(c_addr_i), .c_we_i(c_we_i),
      .c_be_i(c_be_i), .c_wdata_i(c_wdata_i), .c_rvalid_o(c_rvalid_o),
      .c_err_o(c_err_o), .c_rdata_o(c_rdata_o),
      .p_req_i(p_req_i), .p_addr_i(p_addr_i), .p_we_i(p_we_i), .p_wdata_i(p_wdata_i),
      .p_gnt_o(p_gnt_o), .p_rvalid_o(p_rvalid_o), .p_err_o(p_err_o), .p_rdata_o(p_rdata_o),
      .m_req_o(m_req_o), .m_addr_o(m_addr_o), .m_we_o(m_we_o), .m_be_o(m_be_o),
      .m_wdata_o(m_wdata_o), .m_gnt_i(m_gnt_i), .m_rvalid_i(m_rvalid_i),
      .m_err_i(m_err_i), .m_rdata_i(m_rdata_i),
      .outst_o(outst_o), .spurious_o(spurious_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog expired before end of test");
      $fatal(1, "watchdog");
   end

   // ---------------------------------------------------------------------
   // Checking and reference model
   // ---------------------------------------------------------------------
   int checks   = 0;
   int failures = 0;

   typedef struct packed {
      logic        own;
      logic [31:0] data;
      logic        err;
   } rsp_t;

   int   m_cnt;
   bit   m_last, m_spur;
   bit   own_q[$];
   rsp_t rsp_q[$];
   bit   auto_rsp;
   int   n_c, n_p;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // One clock cycle: inputs are already applied (at posedge+1); compare at
   // the negedge, then advance the model to the next posedge.
   task automatic tick();
      bit   sel_p, sreq, mreq, hs, pop, o, ec, ep;
      rsp_t r;
      @(negedge clk);
      sel_p = prog_mode_i ? 1'b1 : (p_req_i && (!c_req_i || !m_last));
      sreq  = sel_p ? p_req_i : c_req_i;
      mreq  = sreq && (m_cnt < OUTST);
      hs    = mreq && m_gnt_i;
      chk("m_req",    m_req_o,    mreq);
      chk("c_gnt",    c_gnt_o,    hs && !sel_p);
      chk("p_gnt",    p_gnt_o,    hs && sel_p);
      chk("outst",    outst_o,    m_cnt);
      chk("spurious", spurious_o, m_spur);
      if (mreq) begin
         chk("m_addr",  m_addr_o,  sel_p ? p_addr_i  : c_addr_i);
         chk("m_be",    m_be_o,    sel_p ? 4'hF      : c_be_i);
         chk("m_we",    m_we_o,    sel_p ? p_we_i    : c_we_i);
         chk("m_wdata", m_wdata_o, sel_p ? p_wdata_i : c_wdata_i);
      end
      ec = 1'b0;
      ep = 1'b0;
      r  = '0;
      if (rsp_q.size() != 0) begin
         r  = rsp_q.pop_front();
         ec = !r.own;
         ep = r.own;
      end
      chk("c_rvalid", c_rvalid_o, ec);
      chk("p_rvalid", p_rvalid_o, ep);
      if (ec) begin
         chk("c_rdata", c_rdata_o, r.data);
         chk("c_err",   c_err_o,   r.err);
      end
      if (ep) begin
         chk("p_rdata", p_rdata_o, r.data);
         chk("p_err",   p_err_o,   r.err);
      end
      n_c += int'(c_gnt_o);
      n_p += int'(p_gnt_o);
      pop = m_rvalid_i && (m_cnt != 0);
      if (m_rvalid_i && m_cnt == 0) m_spur = 1'b1;
      if (pop) begin
         o      = own_q.pop_front();
         r.own  = o;
         r.data = m_rdata_i;
         r.err  = m_err_i;
         rsp_q.push_back(r);
      end
      if (hs) begin
         own_q.push_back(sel_p);
         m_last = sel_p;
      end
      m_cnt = m_cnt + int'(hs) - int'(pop);
      @(posedge clk);
      #1;
      if (auto_rsp) m_rvalid_i = hs;
      m_rdata_i = $urandom;
      m_err_i   = 1'b0;
   endtask

   // Asynchronous reset mid-cycle with both ports requesting; called at
   // posedge+1, returns at posedge+1 with reset released and requests idle.
   task automatic do_reset();
      c_req_i    = 1'b1;
      p_req_i    = 1'b1;
      m_gnt_i    = 1'b1;
      m_rvalid_i = 1'b0;
      #2 rst = 1'b0;
      #1;
      chk("rst_outst",    outst_o,    0);
      chk("rst_m_req",    m_req_o,    0);
      chk("rst_c_gnt",    c_gnt_o,    0);
      chk("rst_p_gnt",    p_gnt_o,    0);
      chk("rst_c_rvalid", c_rvalid_o, 0);
      chk("rst_p_rvalid", p_rvalid_o, 0);
      chk("rst_spurious", spurious_o, 0);
      chk("rst_rdata",    {c_rdata_o, p_rdata_o}, 64'h0);
      m_cnt  = 0;
      m_last = 1'b1;
      m_spur = 1'b0;
      own_q.delete();
      rsp_q.delete();
      c_req_i = 1'b0;
      p_req_i = 1'b0;
      @(posedge clk);
      #1 rst = 1'b1;
   endtask

   // ---------------------------------------------------------------------
   // Vector table: one cycle per row, starting right after reset
   // ---------------------------------------------------------------------
   typedef struct {
      logic prog, c, p, g, rv;   // inputs
      logic ec, ep, emr;         // expected c_gnt, p_gnt, m_req
   } vec_t;
   vec_t tbl [9];

   initial begin
      //            prog c  p  g  rv   ec ep emr
      tbl[0] = '{1'b0,1'b1,1'b1,1'b1,1'b0, 1'b1,1'b0,1'b1}; // tie, core first
      tbl[1] = '{1'b0,1'b1,1'b1,1'b1,1'b1, 1'b0,1'b1,1'b1}; // tie, loader next
      tbl[2] = '{1'b0,1'b1,1'b0,1'b1,1'b1, 1'b1,1'b0,1'b1}; // lone core
      tbl[3] = '{1'b0,1'b1,1'b0,1'b1,1'b1, 1'b1,1'b0,1'b1}; // lone core again
      tbl[4] = '{1'b0,1'b0,1'b1,1'b0,1'b1, 1'b0,1'b0,1'b1}; // no downstream grant
      tbl[5] = '{1'b1,1'b1,1'b0,1'b1,1'b0, 1'b0,1'b0,1'b0}; // prog: core locked out
      tbl[6] = '{1'b1,1'b1,1'b1,1'b1,1'b0, 1'b0,1'b1,1'b1}; // prog: loader only
      tbl[7] = '{1'b0,1'b1,1'b1,1'b1,1'b1, 1'b1,1'b0,1'b1}; // back to RR: core
      tbl[8] = '{1'b0,1'b0,1'b0,1'b1,1'b1, 1'b0,1'b0,1'b0}; // idle, last response

      rst = 1'b0; prog_mode_i = 1'b0;
      c_req_i = 1'b0; c_we_i = 1'b0; c_addr_i = '0; c_be_i = '0; c_wdata_i = '0;
      p_req_i = 1'b0; p_we_i = 1'b0; p_addr_i = '0; p_wdata_i = '0;
      m_gnt_i = 1'b0; m_rvalid_i = 1'b0; m_err_i = 1'b0; m_rdata_i = '0;
      m_cnt = 0; m_last = 1'b1; m_spur = 1'b0; auto_rsp = 1'b0; n_c = 0; n_p = 0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;

      for (int i = 0; i < 9; i++) begin
         prog_mode_i = tbl[i].prog;
         c_req_i     = tbl[i].c;
         p_req_i     = tbl[i].p;
         m_gnt_i     = tbl[i].g;
         m_rvalid_i  = tbl[i].rv;
         c_addr_i    = 32'(32'h1000 + i * 4);
         p_addr_i    = 32'(32'h2000 + i * 4);
         c_be_i      = 4'h5;
         c_we_i      = i[0];
         p_we_i      = ~i[0];
         c_wdata_i   = $urandom;
         p_wdata_i   = $urandom;
         #3;
         chk("tbl_c_gnt", c_gnt_o, tbl[i].ec);
         chk("tbl_p_gnt", p_gnt_o, tbl[i].ep);
         chk("tbl_m_req", m_req_o, tbl[i].emr);
         tick();
      end
      m_rvalid_i = 1'b0;
      tick();

      // Continuous reads from both ports with single-cycle responses.
      do_reset();
      c_we_i = 1'b0; p_we_i = 1'b0; prog_mode_i = 1'b0;
      c_req_i = 1'b1; p_req_i = 1'b1; m_gnt_i = 1'b1; auto_rsp = 1'b1;
      n_c = 0; n_p = 0;
      tick();
      chk("rr_first_is_core", {n_c, n_p}, {32'd1, 32'd0});
      repeat (7) tick();
      chk("rr_alternate", {n_c, n_p}, {32'd4, 32'd4});
      c_req_i = 1'b0; p_req_i = 1'b0;
      repeat (3) tick();

      // Programming mode lock-out, then release.
      prog_mode_i = 1'b1; c_req_i = 1'b1; p_req_i = 1'b1;
      n_c = 0; n_p = 0;
      repeat (10) tick();
      chk("prog_no_core", {n_c, n_p}, {32'd0, 32'd10});
      prog_mode_i = 1'b0;
      n_c = 0;
      repeat (2) tick();
      chk("prog_exit_core_within2", n_c >= 1, 1);
      c_req_i = 1'b0; p_req_i = 1'b0;
      repeat (3) tick();

      // Outstanding limit with no responses.
      do_reset();
      auto_rsp = 1'b0; m_rvalid_i = 1'b0;
      c_req_i = 1'b1; p_req_i = 1'b1;
      n_c = 0; n_p = 0;
      repeat (6) tick();
      #3;
      chk("full_grants", n_c + n_p, 4);
      chk("full_outst",  outst_o, 4);
      chk("full_m_req",  m_req_o, 0);
      m_rvalid_i = 1'b1;
      tick();
      chk("full_pop_no_grant", n_c + n_p, 4);
      m_rvalid_i = 1'b0;
      tick();
      chk("full_next_grant", n_c + n_p, 5);
      c_req_i = 1'b0; p_req_i = 1'b0;
      m_rvalid_i = 1'b1;
      repeat (4) tick();
      m_rvalid_i = 1'b0;
      repeat (2) tick();

      // Core write then loader read with an error response.
      do_reset();
      c_req_i = 1'b1; c_we_i = 1'b1; c_be_i = 4'b0011; c_wdata_i = 32'hDEADBEEF;
      c_addr_i = 32'h40; p_req_i = 1'b0;
      #3;
      chk("wr_be",    m_be_o,    4'b0011);
      chk("wr_wdata", m_wdata_o, 32'hDEADBEEF);
      tick();
      c_req_i = 1'b0; p_req_i = 1'b1; p_we_i = 1'b0; p_addr_i = 32'h80;
      m_rvalid_i = 1'b1; m_err_i = 1'b0;
      #3;
      chk("rd_be_all_ones", m_be_o, 4'hF);
      tick();
      p_req_i = 1'b0; m_rvalid_i = 1'b1; m_err_i = 1'b1; m_rdata_i = 32'h12345678;
      #3;
      chk("wr_resp", {c_rvalid_o, c_err_o}, 2'b10);
      tick();
      m_rvalid_i = 1'b0;
      #3;
      chk("rd_resp",  {p_rvalid_o, p_err_o, c_rvalid_o}, 3'b110);
      chk("rd_rdata", p_rdata_o, 32'h12345678);
      tick();

      // Spurious response with nothing outstanding.
      m_rvalid_i = 1'b1;
      tick();
      m_rvalid_i = 1'b0;
      #3;
      chk("spur_set",       spurious_o, 1);
      chk("spur_no_rvalid", {c_rvalid_o, p_rvalid_o}, 2'b00);
      repeat (3) tick();
      chk("spur_sticky", spurious_o, 1);
      do_reset();

      // Reset with three outstanding, then a late response.
      c_req_i = 1'b1; p_req_i = 1'b1; m_rvalid_i = 1'b0;
      repeat (3) tick();
      c_req_i = 1'b0; p_req_i = 1'b0;
      #3;
      chk("pre_rst_outst", outst_o, 3);
      @(posedge clk);
      #1;
      do_reset();
      m_rvalid_i = 1'b1;
      tick();
      m_rvalid_i = 1'b0;
      repeat (2) tick();
      chk("late_rsp_spur", spurious_o, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
